// File: rtl/gpia_wb_ctrl_pkg.sv
// Shared encodings for the GPIA port controller: output-bit command modes,
// register addresses and the bus acknowledge state.
package gpia_wb_ctrl_pkg;

    localparam int unsigned ADR_W  = 3;
    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] GPIA_MODE_WRITE  = 2'd0;
    localparam logic [MODE_W-1:0] GPIA_MODE_SET    = 2'd1;
    localparam logic [MODE_W-1:0] GPIA_MODE_CLR    = 2'd2;
    localparam logic [MODE_W-1:0] GPIA_MODE_TOGGLE = 2'd3;

    localparam logic [ADR_W-1:0] GPIA_ADR_OUT  = 3'd0;
    localparam logic [ADR_W-1:0] GPIA_ADR_SET  = 3'd1;
    localparam logic [ADR_W-1:0] GPIA_ADR_CLR  = 3'd2;
    localparam logic [ADR_W-1:0] GPIA_ADR_TGL  = 3'd3;
    localparam logic [ADR_W-1:0] GPIA_ADR_EDGE = 3'd4;
    localparam logic [ADR_W-1:0] GPIA_ADR_IN   = 3'd5;
    localparam logic [ADR_W-1:0] GPIA_ADR_MASK = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

    // Addresses 0..3 map one-to-one onto the output-bit command modes.
    function automatic logic is_out_adr(input logic [ADR_W-1:0] adr);
        return adr[ADR_W-1] == 1'b0;
    endfunction

endpackage

// File: rtl/gpia_wb_ctrl_sync_edge.sv
// Input conditioning: two-flop synchroniser, one delay flop and rising-edge detect.
module gpia_sync_edge #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (!res_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= a_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign s_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/gpia_wb_ctrl.sv
// Wishbone slave front-end for one GPIA port: drives the per-bit command bus,
// returns readback/inputs/edges and raises a maskable edge interrupt.
module gpia_wb_ctrl
    import gpia_wb_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              res_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [WIDTH-1:0]  dat_i,
    output logic [WIDTH-1:0]  dat_o,
    output logic              ack_o,
    output logic [MODE_W-1:0] mode_o,
    output logic [WIDTH-1:0]  d_o,
    output logic              bstb_o,
    input  logic [WIDTH-1:0]  q_i,
    input  logic [WIDTH-1:0]  port_i,
    output logic              irq_o
);

    ack_state_e        state_q;
    logic [WIDTH-1:0]  dat_q;
    logic [MODE_W-1:0] mode_q;
    logic [WIDTH-1:0]  d_q;
    logic              bstb_q;
    logic [WIDTH-1:0]  edge_q;
    logic [WIDTH-1:0]  mask_q;
    logic              irq_q;

    logic [WIDTH-1:0]  sync_in;
    logic [WIDTH-1:0]  rise;
    logic              req;
    logic              wr_out;
    logic [WIDTH-1:0]  w1c;
    logic [WIDTH-1:0]  edge_d;
    logic [WIDTH-1:0]  rd_data;

    gpia_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
        .clk_i  (clk_i),
        .res_i  (res_i),
        .a_i    (port_i),
        .s_o    (sync_in),
        .rise_o (rise)
    );

    // A request is only taken while not acking, so back-to-back strobes alternate.
    assign req    = cyc_i & stb_i & (state_q == ST_IDLE);
    assign wr_out = req & we_i & is_out_adr(adr_i);
    assign w1c    = (req && we_i && adr_i == GPIA_ADR_EDGE) ? dat_i : '0;
    // Clearing first, then setting, lets a same-cycle rise win over W1C.
    assign edge_d = (edge_q & ~w1c) | rise;

    always_comb begin
        rd_data = '0;
        case (adr_i)
            GPIA_ADR_OUT, GPIA_ADR_SET,
            GPIA_ADR_CLR, GPIA_ADR_TGL: rd_data = q_i;
            GPIA_ADR_EDGE:              rd_data = edge_q;
            GPIA_ADR_IN:                rd_data = sync_in;
            GPIA_ADR_MASK:              rd_data = mask_q;
            default:                    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!res_i) begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
            mode_q  <= '0;
            d_q     <= '0;
            bstb_q  <= 1'b0;
            edge_q  <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= req ? ST_ACK : ST_IDLE;
            bstb_q  <= wr_out;
            if (wr_out) begin
                mode_q <= adr_i[MODE_W-1:0];
                d_q    <= dat_i;
            end
            if (req) begin
                dat_q <= rd_data;
            end
            if (req && we_i && adr_i == GPIA_ADR_MASK) begin
                mask_q <= dat_i;
            end
            edge_q <= edge_d;
            irq_q  <= |(edge_q & mask_q);
        end
    end

    assign ack_o  = (state_q == ST_ACK);
    assign dat_o  = dat_q;
    assign mode_o = mode_q;
    assign d_o    = d_q;
    assign bstb_o = bstb_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpia_wb_ctrl.sv
// Directed bench for gpia_wb_ctrl with a behavioural model of the output-bit array.
module tb_gpia_wb_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic         we  = 1'b0;
    logic [2:0]   adr = '0;
    logic [W-1:0] dat = '0;
    logic [W-1:0] dat_o;
    logic         ack_o;
    logic [1:0]   mode_o;
    logic [W-1:0] d_o;
    logic         bstb_o;
    logic [W-1:0] q_i;
    logic [W-1:0] port = '0;
    logic         irq_o;

    int checks   = 0;
    int failures = 0;

    gpia_wb_ctrl #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .res_i  (res),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .we_i   (we),
        .adr_i  (adr),
        .dat_i  (dat),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .mode_o (mode_o),
        .d_o    (d_o),
        .bstb_o (bstb_o),
        .q_i    (q_i),
        .port_i (port),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    // Output-bit array model: 0=write 1=set 2=clear 3=toggle
    logic [W-1:0] q_model;
    always @(posedge clk) begin
        if (!res) q_model <= '0;
        else if (bstb_o) begin
            case (mode_o)
                2'd0: q_model <= d_o;
                2'd1: q_model <= q_model | d_o;
                2'd2: q_model <= q_model & ~d_o;
                default: q_model <= q_model ^ d_o;
            endcase
        end
    end
    assign q_i = q_model;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; returns signals seen in the ack cycle, then idles one cycle.
    task automatic bus(input logic w, input logic [2:0] a, input logic [W-1:0] dv,
                       output logic [W-1:0] rd, output logic b, output logic [1:0] m,
                       output logic [W-1:0] dd);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = dv;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack_o && n < 4);
        checks++;
        if (ack_o !== 1'b1) begin
            failures++;
            $display("FAIL ack_seen adr=%0d got=%b want=1", a, ack_o);
        end
        rd = dat_o; b = bstb_o; m = mode_o; dd = d_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(1);
    endtask

    logic [W-1:0] rd, dd;
    logic         b;
    logic [1:0]   m;

    task automatic test_reset();
        res = 1'b0;
        step(3);
        checks++;
        if ({ack_o, bstb_o, irq_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000", {ack_o, bstb_o, irq_o});
        end
        checks++;
        if ({dat_o, mode_o, d_o} !== '0) begin
            failures++;
            $display("FAIL reset_data dat=%h mode=%0d d=%h want=0", dat_o, mode_o, d_o);
        end
        res = 1'b1;
        step(1);
    endtask

    task automatic test_write_modes();
        bus(1'b1, 3'd0, 16'h00F0, rd, b, m, dd);
        checks++;
        if ({b, m, dd} !== {1'b1, 2'd0, 16'h00F0}) begin
            failures++;
            $display("FAIL wr_out_cmd got b=%b m=%0d d=%h want b=1 m=0 d=00f0", b, m, dd);
        end
        checks++;
        if (bstb_o !== 1'b0) begin
            failures++;
            $display("FAIL bstb_one_cycle got=%b want=0", bstb_o);
        end
        bus(1'b1, 3'd1, 16'h0003, rd, b, m, dd);
        checks++;
        if ({b, m, dd} !== {1'b1, 2'd1, 16'h0003}) begin
            failures++;
            $display("FAIL wr_set_cmd got b=%b m=%0d d=%h want b=1 m=1 d=0003", b, m, dd);
        end
        checks++;
        if (q_i !== 16'h00F3) begin
            failures++;
            $display("FAIL q_after_set got=%h want=00f3", q_i);
        end
        bus(1'b0, 3'd0, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h00F3 || b !== 1'b0) begin
            failures++;
            $display("FAIL rd_out got=%h bstb=%b want=00f3 bstb=0", rd, b);
        end
        bus(1'b1, 3'd2, 16'h0011, rd, b, m, dd);
        checks++;
        if (q_i !== 16'h00E2) begin
            failures++;
            $display("FAIL q_after_clr got=%h want=00e2", q_i);
        end
        bus(1'b1, 3'd3, 16'h0101, rd, b, m, dd);
        checks++;
        if (q_i !== 16'h01E3 || m !== 2'd3) begin
            failures++;
            $display("FAIL q_after_tgl got=%h m=%0d want=01e3 m=3", q_i, m);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] acks;
        int pulses = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dat = 16'h1000;
        acks[0] = ack_o;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk);
            #1;
            acks[k] = ack_o;
            if (bstb_o) pulses++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(2);
        checks++;
        if (acks !== 6'b101010) begin
            failures++;
            $display("FAIL b2b_ack_pattern got=%b want=101010 (bit0 first)", acks);
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL b2b_bstb_count got=%0d want=3", pulses);
        end
        checks++;
        if (q_i !== 16'h11E3) begin
            failures++;
            $display("FAIL b2b_q got=%h want=11e3", q_i);
        end
    endtask

    task automatic test_edge_irq();
        logic [3:0] irqs;
        bus(1'b1, 3'd6, 16'h0008, rd, b, m, dd);
        port = 16'h0008;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            irqs[k] = irq_o;
        end
        checks++;
        if (irqs !== 4'b1000) begin
            failures++;
            $display("FAIL irq_latency got=%b want=1000 (bit0 first clock)", irqs);
        end
        bus(1'b0, 3'd4, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0008) begin
            failures++;
            $display("FAIL rd_edge got=%h want=0008", rd);
        end
        bus(1'b0, 3'd5, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0008) begin
            failures++;
            $display("FAIL rd_sync_in got=%h want=0008", rd);
        end
        bus(1'b0, 3'd6, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0008) begin
            failures++;
            $display("FAIL rd_mask got=%h want=0008", rd);
        end
        bus(1'b1, 3'd4, 16'h0008, rd, b, m, dd);
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL irq_after_w1c got=%b want=0", irq_o);
        end
        bus(1'b0, 3'd4, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL edge_after_w1c got=%h want=0000", rd);
        end
    endtask

    task automatic test_ignored_regs();
        bus(1'b1, 3'd5, 16'hFFFF, rd, b, m, dd);
        checks++;
        if (b !== 1'b0) begin
            failures++;
            $display("FAIL wr_adr5_bstb got=%b want=0", b);
        end
        bus(1'b1, 3'd7, 16'hFFFF, rd, b, m, dd);
        bus(1'b0, 3'd7, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL rd_adr7 got=%h want=0000", rd);
        end
        bus(1'b0, 3'd6, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0008) begin
            failures++;
            $display("FAIL mask_unchanged got=%h want=0008", rd);
        end
    endtask

    task automatic test_set_beats_w1c();
        port = 16'h0000;
        step(4);
        port = 16'h0008;
        step(2);
        // Request lands on the same edge that the rise is latched.
        bus(1'b1, 3'd4, 16'h0008, rd, b, m, dd);
        bus(1'b0, 3'd4, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0008) begin
            failures++;
            $display("FAIL set_beats_w1c got=%h want=0008", rd);
        end
        checks++;
        if (irq_o !== 1'b1) begin
            failures++;
            $display("FAIL irq_after_collision got=%b want=1", irq_o);
        end
    endtask

    task automatic test_reset_mid_access();
        port = 16'h0000;
        step(4);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd6;
        step(1);
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 16'h0008) begin
            failures++;
            $display("FAIL pre_reset_read ack=%b dat=%h want ack=1 dat=0008", ack_o, dat_o);
        end
        res = 1'b0; cyc = 1'b0; stb = 1'b0;
        step(1);
        checks++;
        if ({ack_o, bstb_o, irq_o, dat_o, mode_o, d_o} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs ack=%b bstb=%b irq=%b dat=%h mode=%0d d=%h want all 0",
                     ack_o, bstb_o, irq_o, dat_o, mode_o, d_o);
        end
        res = 1'b1;
        step(1);
        bus(1'b0, 3'd4, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL edge_after_reset got=%h want=0000", rd);
        end
        bus(1'b0, 3'd6, 16'h0000, rd, b, m, dd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++;
            $display("FAIL mask_after_reset got=%h want=0000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_modes();
        test_back_to_back();
        test_edge_irq();
        test_ignored_regs();
        test_set_beats_w1c();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
